// File: rtl/lcd_cmd_arbiter_if.sv
// Command/text bus between requesters, the arbiter and the LCD driver.
// Requester k occupies i_req_cmd[3k+2:3k] = {line2, line1, clear} and the 128-bit
// slices [128k+127:128k] of i_req_line1 / i_req_line2.
//   slave  : arbiter side (requests and driver-ready in, strobes/text/status out)
//   master : environment side (requesters plus LCD driver)
interface lcd_cmd_arbiter_if;
  logic [8:0]   i_req_cmd;
  logic [383:0] i_req_line1;
  logic [383:0] i_req_line2;
  logic         i_lcd_command_ready;

  logic         o_lcd_wr_clear_display;
  logic         o_lcd_wr_text_line1;
  logic         o_lcd_wr_text_line2;
  logic [127:0] o_lcd_dat_ascii_line1;
  logic [127:0] o_lcd_dat_ascii_line2;
  logic [2:0]   o_grant;
  logic [2:0]   o_ack;
  logic         o_error;
  logic         o_busy;

  modport slave (
    input  i_req_cmd, i_req_line1, i_req_line2, i_lcd_command_ready,
    output o_lcd_wr_clear_display, o_lcd_wr_text_line1, o_lcd_wr_text_line2,
    output o_lcd_dat_ascii_line1, o_lcd_dat_ascii_line2,
    output o_grant, o_ack, o_error, o_busy
  );

  modport master (
    output i_req_cmd, i_req_line1, i_req_line2, i_lcd_command_ready,
    input  o_lcd_wr_clear_display, o_lcd_wr_text_line1, o_lcd_wr_text_line2,
    input  o_lcd_dat_ascii_line1, o_lcd_dat_ascii_line2,
    input  o_grant, o_ack, o_error, o_busy
  );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter sharing one LCD command driver between three requesters.
// A grant latches one command (clear > line1 > line2) and both text lines of the
// winner, strobes the command until the driver drops ready, waits for ready to
// return, then pulses ack (and error if the driver never reacted) for one CE period.
// Ports:
//   i_clk_20mhz    20 MHz clock
//   i_rst_20mhz_n  asynchronous active-low reset
//   i_ce_2_5mhz    clock enable; all state advances only when high
//   bus            lcd_cmd_arbiter_if.slave (requests, driver ready, strobes, text, status)
module lcd_cmd_arbiter #(
  parameter bit          parm_fast_simulation = 1'b0,
  parameter int unsigned parm_num_req         = 3
) (
  input  logic             i_clk_20mhz,
  input  logic             i_rst_20mhz_n,
  input  logic             i_ce_2_5mhz,
  lcd_cmd_arbiter_if.slave bus
);

  // Last counter value of the issue phase; the strobe is high for (value + 1) ticks.
  localparam logic [11:0] IssueLastTick = parm_fast_simulation ? 12'd249 : 12'd2499;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e       state_q;
  logic [1:0]   winner_q;
  logic [1:0]   rr_ptr_q;
  logic [2:0]   cmd_q;      // one-hot {line2, line1, clear}
  logic [127:0] line1_q;
  logic [127:0] line2_q;
  logic [11:0]  cnt_q;
  logic         err_q;

  logic [3:0]   req_any;    // bit 3 pads the index range of the 2-bit pointer
  logic [1:0]   cand1;
  logic [1:0]   cand2;
  logic [1:0]   win_idx;
  logic [2:0]   win_bits;
  logic [2:0]   win_cmd;
  logic [11:0]  cnt_inc;

  function automatic logic [1:0] rr_next(logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  always_comb begin
    req_any = '0;
    for (int k = 0; k < int'(parm_num_req); k++) begin
      req_any[k] = |bus.i_req_cmd[3*k +: 3];
    end
  end

  // Search order rr_ptr+1, rr_ptr+2, rr_ptr.
  assign cand1 = rr_next(rr_ptr_q);
  assign cand2 = rr_next(cand1);

  always_comb begin
    if (req_any[cand1]) begin
      win_idx = cand1;
    end else if (req_any[cand2]) begin
      win_idx = cand2;
    end else begin
      win_idx = rr_ptr_q;
    end
  end

  assign win_bits = bus.i_req_cmd[3*int'(win_idx) +: 3];

  always_comb begin
    if (win_bits[0]) begin
      win_cmd = 3'b001;
    end else if (win_bits[1]) begin
      win_cmd = 3'b010;
    end else begin
      win_cmd = 3'b100;
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 12'd1;

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
    if (!i_rst_20mhz_n) begin
      state_q  <= StIdle;
      winner_q <= 2'd0;
      rr_ptr_q <= 2'd2;
      cmd_q    <= 3'b000;
      line1_q  <= '0;
      line2_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (i_ce_2_5mhz) begin
      case (state_q)
        StIdle: begin
          if (bus.i_lcd_command_ready && (|req_any)) begin
            state_q  <= StIssue;
            winner_q <= win_idx;
            cmd_q    <= win_cmd;
            line1_q  <= bus.i_req_line1[128*int'(win_idx) +: 128];
            line2_q  <= bus.i_req_line2[128*int'(win_idx) +: 128];
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StIssue: begin
          if (!bus.i_lcd_command_ready) begin
            state_q <= StWait;
            cnt_q   <= '0;
          end else if (cnt_q == IssueLastTick) begin
            // Driver never accepted the strobe: give up and report it.
            state_q <= StDone;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWait: begin
          if (bus.i_lcd_command_ready) begin
            state_q <= StDone;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StDone: begin
          rr_ptr_q <= winner_q;
          err_q    <= 1'b0;
          state_q  <= StIdle;
          cnt_q    <= '0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  assign bus.o_busy                 = (state_q != StIdle);
  assign bus.o_grant                = (state_q != StIdle) ? (3'b001 << winner_q) : 3'b000;
  assign bus.o_lcd_wr_clear_display = (state_q == StIssue) && cmd_q[0];
  assign bus.o_lcd_wr_text_line1    = (state_q == StIssue) && cmd_q[1];
  assign bus.o_lcd_wr_text_line2    = (state_q == StIssue) && cmd_q[2];
  assign bus.o_ack                  = (state_q == StDone) ? (3'b001 << winner_q) : 3'b000;
  assign bus.o_error                = (state_q == StDone) && err_q;
  assign bus.o_lcd_dat_ascii_line1  = line1_q;
  assign bus.o_lcd_dat_ascii_line2  = line2_q;

endmodule

// File: doc/lcd_cmd_arbiter.md
LCD_CMD_ARBITER -- requirements
Module: lcd_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter parm_fast_simulation, default 0, meaning 1 selects a 250-tick issue timeout and 0 selects 2500 ticks.
REQ-002 The block SHALL have parameter parm_num_req, fixed at 3, meaning the number of requesters.
REQ-003 Port i_clk_20mhz  in  1  is the single 20 MHz clock.
REQ-004 Port i_rst_20mhz_n  in  1  is the reset: asynchronous, active-low.
REQ-005 Port i_ce_2_5mhz  in  1  is the clock enable; all state, counter and pointer updates occur only on cycles with CE=1.
REQ-006 Port i_req_cmd  in  9  carries requester k's command request at bits [3k+2:3k] = {line2, line1, clear}; each bit is a level held until acknowledged.
REQ-007 Port i_req_line1  in  384  carries requester k's 16 ASCII bytes for line 1 at bits [128k+127:128k].
REQ-008 Port i_req_line2  in  384  carries requester k's 16 ASCII bytes for line 2, packed the same way.
REQ-009 Port i_lcd_command_ready  in  1  is the LCD driver's idle/ready flag.
REQ-010 Port o_lcd_wr_clear_display / o_lcd_wr_text_line1 / o_lcd_wr_text_line2  out  1 each  are the command strobes to the driver.
REQ-011 Port o_lcd_dat_ascii_line1 / o_lcd_dat_ascii_line2  out  128 each  carry the latched text to the driver.
REQ-012 Port o_grant  out  3  is a one-hot indication of the requester currently owning the driver.
REQ-013 Port o_ack  out  3  is a per-requester completion pulse, one CE period wide.
REQ-014 Port o_error  out  1  is a timeout pulse, one CE period wide, coincident with o_ack.
REQ-015 Port o_busy  out  1  is high whenever the FSM is not in ST_IDLE.

Function
REQ-016 The FSM states SHALL be ST_IDLE, ST_ISSUE, ST_WAIT and ST_DONE; all outputs are decoded from the registered state and registers (Moore).
REQ-017 In ST_IDLE with i_lcd_command_ready=1 and at least one request bit set, the arbiter SHALL grant by round-robin: search starts at rr_ptr+1 mod 3; a requester qualifies if any of its 3 bits is set.
REQ-018 On grant, the block SHALL latch the winner's index, one command, line1 text and line2 text, then go to ST_ISSUE.
REQ-019 Command selection within a requester is fixed priority: clear > line1 > line2.
REQ-020 Text and command latched at grant SHALL NOT change until the return to ST_IDLE, even if the inputs change.
REQ-021 In ST_ISSUE exactly the latched command's strobe SHALL be high; when i_lcd_command_ready=0 the FSM goes to ST_WAIT.
REQ-022 In ST_ISSUE, a 12-bit tick counter SHALL count CE ticks; at timeout-1 with ready still 1, the FSM goes to ST_DONE with an error flag set.
REQ-023 In ST_WAIT all strobes are low; when i_lcd_command_ready=1 the FSM goes to ST_DONE.
REQ-024 ST_WAIT has no timeout.
REQ-025 ST_DONE SHALL last one CE period: o_ack[winner]=1, o_error equals the error flag, then rr_ptr:=winner, the error flag clears, and the FSM goes to ST_IDLE.
REQ-026 o_grant SHALL be one-hot of the winner in ST_ISSUE, ST_WAIT and ST_DONE, and 0 in ST_IDLE.
REQ-027 The tick counter SHALL be cleared on every state change and SHALL saturate and never wrap.
REQ-028 A requester dropping its request mid-command SHALL NOT abort the command.
REQ-029 A requester SHALL clear the acknowledged bit within one CE period after o_ack; remaining bits re-arbitrate normally.
REQ-030 If requests arrive in ST_IDLE while ready=0, the FSM SHALL remain in ST_IDLE.
REQ-031 Simultaneous requests from all 3 requesters SHALL be served in order rr_ptr+1, rr_ptr+2, rr_ptr, one command each.
REQ-032 o_lcd_dat_ascii_line1/2 SHALL hold the last latched values when idle.

Reset
REQ-033 Asserting i_rst_20mhz_n=0 at any time SHALL immediately set: state ST_IDLE; rr_ptr=2, so requester 0 wins first; counter 0; error flag 0; all strobes, o_grant, o_ack, o_error and o_busy 0; both text outputs all-zero.
REQ-034 Reset deassertion SHALL take effect on a clock edge; a command in flight is abandoned without ack.

Verification
REQ-035 After reset, requester 1 asserts line1 with ready=1 -> o_grant=3'b010, o_lcd_wr_text_line1 high until ready falls; ready rises 100 ticks later -> o_ack=3'b010 for one CE, o_error=0.
REQ-036 All three requesters assert clear simultaneously with rr_ptr=2 -> grants in order 0, 1, 2, each followed by an ack pulse.
REQ-037 Requester 0 asserts {line2,line1,clear}=3'b111 -> clear, then line1, then line2 issued in consecutive arbitrations, interleaved round-robin with any other requester.
REQ-038 parm_fast_simulation=1, ready held 1 after grant -> strobe high exactly 250 ticks, then o_ack and o_error both pulse and the FSM returns to ST_IDLE.
REQ-039 Reset asserted while in ST_WAIT -> all outputs 0 asynchronously; after release, requester 0 wins the next grant.
REQ-040 Requester 2's line1 text changes during ST_WAIT -> o_lcd_dat_ascii_line1 keeps the value latched at grant.
